// File: rtl/bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int           BCD_DIGIT_W    = 4;
    localparam logic [3:0]   BCD_ADJ_THRESH = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 10^n as a 64-bit value; the widest case (10^10) does not fit in 32 bits.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // True when the largest BIN_W-bit input can reach 10^DIGITS.
    function automatic bit ovf_possible(input int bin_w, input int digits);
        longint unsigned max_in;
        max_in = (64'd1 << bin_w) - 64'd1;
        return (pow10(digits) <= max_in);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional build macro BIN2BCD_SAT_EN: on overflow the result saturates to
// all nines instead of holding the truncated low digits.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_din,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf
);

    localparam int WORK_W       = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W        = $clog2(BIN_W + 1);
    localparam bit OVF_POSSIBLE = ovf_possible(BIN_W, DIGITS);

    state_t             r_state;
    state_t             w_next;
    logic               r_start_q;
    logic               w_start_edge;
    logic [BIN_W-1:0]   r_sreg;
    logic [WORK_W-1:0]  r_work;
    logic [WORK_W-1:0]  w_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_acc;
    logic               w_last;
    logic               w_load;
    logic               w_shift;
    logic               w_finish;
    logic               w_top_ge10;
    logic               w_ovf_final;
    logic [WORK_W-1:0]  w_result;

    assign w_start_edge = i_start & ~r_start_q;
    assign w_last       = (r_cnt == CNT_W'(1));

    // One correction cell per BCD digit of the working register.
    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .i_digit (r_work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Start level history for rising-edge detection; tracks even while busy.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_start_q <= 1'b0;
        else       r_start_q <= i_start;
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // FSM next-state logic; start edges outside IDLE are dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_edge) w_next = SHIFT;
            SHIFT:   if (w_last)       w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM output decode driving the datapath.
    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE:    w_load   = w_start_edge;
            SHIFT:   w_shift  = 1'b1;
            DONE:    w_finish = 1'b1;
            default: ;
        endcase
    end

    // Shift datapath: adjust digits, shift {work, sreg} left, collect lost bits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sreg    <= '0;
            r_work    <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
        end else if (w_load) begin
            r_sreg    <= i_din;
            r_work    <= '0;
            r_cnt     <= CNT_W'(BIN_W);
            r_ovf_acc <= 1'b0;
        end else if (w_shift) begin
            r_work    <= {w_adj[WORK_W-2:0], r_sreg[BIN_W-1]};
            r_sreg    <= r_sreg << 1;
            r_ovf_acc <= r_ovf_acc | w_adj[WORK_W-1];
            r_cnt     <= r_cnt - CNT_W'(1);
        end
    end

    // A top digit above 9 would also mean the value did not fit; when the
    // input range cannot reach 10^DIGITS the flag is tied off entirely.
    assign w_top_ge10  = (r_work[WORK_W-1 -: BCD_DIGIT_W] > 4'd9);
    assign w_ovf_final = OVF_POSSIBLE & (r_ovf_acc | w_top_ge10);

`ifdef BIN2BCD_SAT_EN
    assign w_result = w_ovf_final ? {DIGITS{4'h9}} : r_work;
`else
    assign w_result = r_work;
`endif

    // Result registers and handshake; bcd/ovf only change on the done cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bcd  <= '0;
            o_ovf  <= 1'b0;
            o_done <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            o_done <= w_finish;
            if (w_load)        o_busy <= 1'b1;
            else if (w_finish) o_busy <= 1'b0;
            if (w_finish) begin
                o_bcd <= w_result;
                o_ovf <= w_ovf_final;
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: three configurations driven in parallel
// (7b/2 digits, 7b/3 digits, 16b/5 digits), expected results from decimal arithmetic.
module tb_bin2bcd_seq;

    typedef struct packed {
        logic [63:0] bcd;
        logic        ovf;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] din = '0;

    logic        busy_a, done_a, ovf_a;
    logic [7:0]  bcd_a;
    logic        busy_b, done_b, ovf_b;
    logic [11:0] bcd_b;
    logic        busy_c, done_c, ovf_c;
    logic [19:0] bcd_c;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   run_a = 0, run_b = 0, run_c = 0;
    int   dcnt_a = 0, dcnt_c = 0;
    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    bin2bcd_seq #(.BIN_W(7), .DIGITS(2)) u_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_din(din[6:0]),
        .o_busy(busy_a), .o_done(done_a), .o_bcd(bcd_a), .o_ovf(ovf_a));
    bin2bcd_seq #(.BIN_W(7), .DIGITS(3)) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_din(din[6:0]),
        .o_busy(busy_b), .o_done(done_b), .o_bcd(bcd_b), .o_ovf(ovf_b));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_din(din[15:0]),
        .o_busy(busy_c), .o_done(done_c), .o_bcd(bcd_c), .o_ovf(ovf_c));

    // Reference: decimal digits by division, done arrives BIN_W+1 edges after the start edge.
    function automatic exp_t model(input longint unsigned v, input int digits,
                                   input int bin_w, input int issue_cyc);
        exp_t            e;
        longint unsigned lim;
        longint unsigned vv;
        lim = 64'd1;
        for (int i = 0; i < digits; i++) lim = lim * 64'd10;
        vv    = v;
        e.ovf = (v >= lim);
`ifdef BIN2BCD_SAT_EN
        if (e.ovf) vv = lim - 64'd1;
`endif
        e.bcd = '0;
        for (int k = 0; k < digits; k++) begin
            e.bcd[4*k +: 4] = 4'(vv % 64'd10);
            vv = vv / 64'd10;
        end
        e.cyc = 32'(issue_cyc + bin_w + 2);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic push_all(input logic [31:0] v);
        qa.push_back(model(64'(v & 32'h7f),   2, 7,  cyc));
        qb.push_back(model(64'(v & 32'h7f),   3, 7,  cyc));
        qc.push_back(model(64'(v & 32'hffff), 5, 16, cyc));
    endtask

    task automatic issue(input logic [31:0] v, input bit hold);
        @(negedge clk);
        din   = v;
        start = 1'b1;
        push_all(v);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if ((qa.size() + qb.size() + qc.size()) != 0) begin
            n_err++;
            $display("FAIL done_timeout pending a=%0d b=%0d c=%0d want 0", qa.size(), qb.size(), qc.size());
            qa.delete(); qb.delete(); qc.delete();
        end
        @(negedge clk);
    endtask

    // Monitors: pop and compare on every done pulse, including latency and busy length.
    always @(negedge clk) begin
        if (rst) run_a = 0; else if (busy_a) run_a++;
        if (done_a) begin
            dcnt_a++;
            n_vec++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL a_spurious_done got bcd=%h want no done", bcd_a);
            end else begin
                ea = qa.pop_front();
                if (bcd_a !== ea.bcd[7:0] || ovf_a !== ea.ovf || cyc != int'(ea.cyc) || run_a != 8) begin
                    n_err++;
                    $display("FAIL a_result got bcd=%h ovf=%b cyc=%0d busy=%0d want bcd=%h ovf=%b cyc=%0d busy=8",
                             bcd_a, ovf_a, cyc, run_a, ea.bcd[7:0], ea.ovf, ea.cyc);
                end
            end
            run_a = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) run_b = 0; else if (busy_b) run_b++;
        if (done_b) begin
            n_vec++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL b_spurious_done got bcd=%h want no done", bcd_b);
            end else begin
                eb = qb.pop_front();
                if (bcd_b !== eb.bcd[11:0] || ovf_b !== eb.ovf || cyc != int'(eb.cyc) || run_b != 8) begin
                    n_err++;
                    $display("FAIL b_result got bcd=%h ovf=%b cyc=%0d busy=%0d want bcd=%h ovf=%b cyc=%0d busy=8",
                             bcd_b, ovf_b, cyc, run_b, eb.bcd[11:0], eb.ovf, eb.cyc);
                end
            end
            run_b = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) run_c = 0; else if (busy_c) run_c++;
        if (done_c) begin
            dcnt_c++;
            n_vec++;
            if (qc.size() == 0) begin
                n_err++;
                $display("FAIL c_spurious_done got bcd=%h want no done", bcd_c);
            end else begin
                ec = qc.pop_front();
                if (bcd_c !== ec.bcd[19:0] || ovf_c !== ec.ovf || cyc != int'(ec.cyc) || run_c != 17) begin
                    n_err++;
                    $display("FAIL c_result got bcd=%h ovf=%b cyc=%0d busy=%0d want bcd=%h ovf=%b cyc=%0d busy=17",
                             bcd_c, ovf_c, cyc, run_c, ec.bcd[19:0], ec.ovf, ec.cyc);
                end
            end
            run_c = 0;
        end
    end

    initial begin
        int da, dc;
        logic [31:0] v;

        repeat (3) @(negedge clk);
        chk("reset_state", 64'({busy_a, done_a, ovf_a, bcd_a, busy_b, done_b, ovf_b, bcd_b,
                               busy_c, done_c, ovf_c, bcd_c}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed values: typical, zero, overflow of the 2-digit build, 16-bit max.
        issue(32'd99, 1'b0);    wait_idle();
        issue(32'd0, 1'b0);     wait_idle();
        issue(32'd59, 1'b0);    wait_idle();
        issue(32'd127, 1'b0);   wait_idle();
        issue(32'd65535, 1'b0); wait_idle();

        // Held start plus a re-edge during the conversion: one result, first din.
        da = dcnt_a; dc = dcnt_c;
        issue(32'd33, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b0;
        din   = 32'd77;
        @(negedge clk);
        start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("held_start_dones_a", 64'(dcnt_a - da), 64'd1);
        chk("held_start_dones_c", 64'(dcnt_c - dc), 64'd1);

        // Reset in the middle of a conversion aborts it and clears the result.
        issue(32'd42, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        qa.delete(); qb.delete(); qc.delete();
        @(negedge clk);
        chk("abort_state", 64'({busy_a, done_a, ovf_a, bcd_a, busy_c, done_c, ovf_c, bcd_c}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(32'd42, 1'b0); wait_idle();

        // Start edge coinciding with reset is lost.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; din = 32'd5;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_beats_start", 64'({busy_a, busy_b, busy_c}), 64'd0);

        // Random values, biased partly toward the 7-bit range.
        repeat (40) begin
            if ($urandom_range(0, 3) == 0) v = 32'($urandom_range(0, 127));
            else                           v = 32'($urandom_range(0, 65535));
            issue(v, 1'b0);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
